// File: rtl/bit_field_pkg.sv
// Shared types and encodings for the indexed bit-field blocks.
package bit_field_pkg;

  typedef enum logic [1:0] {
    SET = 2'b00,
    CLR = 2'b01,
    TGL = 2'b10,
    TST = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_SET = 2'b00;
  localparam logic [1:0] MODE_CLR = 2'b01;
  localparam logic [1:0] MODE_TGL = 2'b10;
  localparam logic [1:0] MODE_TST = 2'b11;

endpackage

// File: rtl/bit_field_check.sv
// Combinational validator for a signed (start, length) field against a BITS-wide word.
module bit_field_check #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] i_b,
  input  logic [BITS-1:0] i_l,
  output logic            o_error
);

  // One extra bit so that B + L can never wrap.
  localparam logic signed [BITS:0] LIMIT = (BITS+1)'(BITS);

  logic signed [BITS:0] b_ext;
  logic signed [BITS:0] l_ext;
  logic signed [BITS:0] sum;

  assign b_ext = $signed({i_b[BITS-1], i_b});
  assign l_ext = $signed({i_l[BITS-1], i_l});
  assign sum   = b_ext + l_ext;

  assign o_error = b_ext[BITS]
                || (b_ext >= LIMIT)
                || l_ext[BITS]
                || (l_ext == '0)
                || (sum > LIMIT);

endmodule

// File: rtl/bit_field_sync.sv
// Sequential set/clear/toggle/popcount of a bit field, one bit per clock, with
// valid/ready handshakes on both sides.
module bit_field_sync
  import bit_field_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_mode,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  input  logic [BITS-1:0] i_arg_L,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_result,
  output logic            o_error
);

  localparam int IW = $clog2(BITS);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [BITS-1:0]   a_q, a_d;
  logic [BITS-1:0]   work_q, work_d;
  logic [IW-1:0]     b_q, b_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [BITS-1:0]   result_q, result_d;
  logic              error_q, error_d;

  logic              arg_err;
  logic [IW-1:0]     idx;

  bit_field_check #(.BITS(BITS)) u_check (
    .i_b     (i_arg_B),
    .i_l     (i_arg_L),
    .o_error (arg_err)
  );

  assign idx = b_q + cnt_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    work_d   = work_q;
    b_d      = b_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          mode_d  = mode_t'(i_mode);
          a_d     = i_arg_A;
          b_d     = i_arg_B[IW-1:0];
          last_d  = i_arg_L[IW-1:0] - IW'(1);
          cnt_d   = '0;
          err_d   = arg_err;
          work_d  = (mode_t'(i_mode) == TST && !arg_err) ? '0 : i_arg_A;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Illegal requests spend their single cycle here with A untouched.
        if (err_q) begin
          state_d  = DONE;
          result_d = work_q;
          error_d  = 1'b1;
        end else begin
          case (mode_q)
            SET: work_d[idx] = 1'b1;
            CLR: work_d[idx] = 1'b0;
            TGL: work_d[idx] = ~work_q[idx];
            TST: if (a_q[idx]) work_d = work_q + BITS'(1);
            default: work_d = work_q;
          endcase
          cnt_d = cnt_q + IW'(1);
          if (cnt_q == last_q) begin
            state_d  = DONE;
            result_d = work_d;
            error_d  = 1'b0;
          end
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d  = IDLE;
          result_d = '0;
          error_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mode_q   <= SET;
      a_q      <= '0;
      work_q   <= '0;
      b_q      <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      work_q   <= work_d;
      b_q      <= b_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_bit_field_sync.sv
// Directed, table-driven bench for bit_field_sync at BITS = 32.
module tb_bit_field_sync;
  import bit_field_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_mode;
  logic [31:0] i_arg_A;
  logic [31:0] i_arg_B;
  logic [31:0] i_arg_L;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] l;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  bit_field_sync #(.BITS(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_mode   (i_mode),
    .i_arg_A  (i_arg_A),
    .i_arg_B  (i_arg_B),
    .i_arg_L  (i_arg_L),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_error  (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string tag, input bit scramble);
    int lat;
    chk({tag, " ready_before"}, 32'(o_ready), 32'd1);
    @(negedge clk);
    i_mode  = v.mode;
    i_arg_A = v.a;
    i_arg_B = v.b;
    i_arg_L = v.l;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 100) begin
      if (scramble) begin
        @(negedge clk);
        i_mode  = 2'($urandom);
        i_arg_A = $urandom;
        i_arg_B = $urandom;
        i_arg_L = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " result"}, o_result, v.res);
    chk({tag, " error"}, 32'(o_error), 32'(v.err));
    $display("req %s mode=%0d A=%08h B=%08h L=%08h -> result=%08h error=%0b latency=%0d",
             tag, v.mode, v.a, v.b, v.l, o_result, o_error, lat);
    if (i_ready) begin
      @(posedge clk);
      #1;
      chk({tag, " valid_drop"}, 32'(o_valid), 32'd0);
      chk({tag, " ready_back"}, 32'(o_ready), 32'd1);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{MODE_SET, 32'h0000_0000, 32'd4,        32'd3,        32'h0000_0070, 1'b0, 3};
    vecs[1]  = '{MODE_TGL, 32'hFFFF_FFFF, 32'd30,       32'd2,        32'h3FFF_FFFF, 1'b0, 2};
    vecs[2]  = '{MODE_CLR, 32'hFFFF_FFFF, 32'd0,        32'd32,       32'h0000_0000, 1'b0, 32};
    vecs[3]  = '{MODE_TST, 32'h0000_F0F0, 32'd0,        32'd16,       32'd8,         1'b0, 16};
    vecs[4]  = '{MODE_TST, 32'h8000_0000, 32'd31,       32'd1,        32'd1,         1'b0, 1};
    vecs[5]  = '{MODE_SET, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd1,       32'hDEAD_BEEF, 1'b1, 1};
    vecs[6]  = '{MODE_CLR, 32'hDEAD_BEEF, 32'd32,       32'd1,        32'hDEAD_BEEF, 1'b1, 1};
    vecs[7]  = '{MODE_TGL, 32'hDEAD_BEEF, 32'h8000_0000, 32'd1,       32'hDEAD_BEEF, 1'b1, 1};
    vecs[8]  = '{MODE_TST, 32'hDEAD_BEEF, 32'd0,        32'd0,        32'hDEAD_BEEF, 1'b1, 1};
    vecs[9]  = '{MODE_SET, 32'hDEAD_BEEF, 32'd0,        32'hFFFF_FFFB, 32'hDEAD_BEEF, 1'b1, 1};
    vecs[10] = '{MODE_CLR, 32'hDEAD_BEEF, 32'd28,       32'd5,        32'hDEAD_BEEF, 1'b1, 1};
    vecs[11] = '{MODE_TST, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1};
    vecs[12] = '{MODE_SET, 32'h0000_0000, 32'd31,       32'd1,        32'h8000_0000, 1'b0, 1};
    vecs[13] = '{MODE_CLR, 32'hFFFF_FFFF, 32'd8,        32'd4,        32'hFFFF_F0FF, 1'b0, 4};
    vecs[14] = '{MODE_TST, 32'hA5A5_A5A5, 32'd0,        32'd32,       32'd16,        1'b0, 32};
    vecs[15] = '{MODE_SET, 32'h0000_0000, 32'd28,       32'd4,        32'hF000_0000, 1'b0, 4};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_mode  = 2'b00;
    i_arg_A = '0;
    i_arg_B = '0;
    i_arg_L = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(o_ready), 32'd1);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset result", o_result, 32'd0);
    chk("reset error", 32'(o_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Backpressure: result held while i_valid keeps pushing new arguments.
    i_ready = 1'b0;
    run_req(vecs[0], "bp", 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_mode  = 2'($urandom);
      i_arg_A = $urandom;
      i_arg_B = $urandom_range(0, 10);
      i_arg_L = $urandom_range(1, 4);
      @(posedge clk);
      #1;
      chk($sformatf("bp hold%0d result", c), o_result, 32'h0000_0070);
      chk($sformatf("bp hold%0d ready", c), 32'(o_ready), 32'd0);
      chk($sformatf("bp hold%0d valid", c), 32'(o_valid), 32'd1);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release ready", 32'(o_ready), 32'd1);
    chk("bp release valid", 32'(o_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp no queued request", 32'(o_valid), 32'd0);
    $display("req bp-release ready=%0b valid=%0b", o_ready, o_valid);

    // Reset mid-BUSY: outputs must clear without a clock edge.
    @(negedge clk);
    i_mode  = MODE_SET;
    i_arg_A = 32'h0000_0000;
    i_arg_B = 32'd0;
    i_arg_L = 32'd20;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst ready", 32'(o_ready), 32'd1);
    chk("midrst valid", 32'(o_valid), 32'd0);
    chk("midrst result", o_result, 32'd0);
    chk("midrst error", 32'(o_error), 32'd0);
    $display("req midreset ready=%0b valid=%0b result=%08h", o_ready, o_valid, o_result);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst ready", 32'(o_ready), 32'd1);
    chk("postrst valid", 32'(o_valid), 32'd0);

    // New request after reset, with argument churn while BUSY.
    v = '{MODE_TGL, 32'h0F0F_0F0F, 32'd8, 32'd8, 32'h0F0F_F00F, 1'b0, 8};
    run_req(v, "postrst_scramble", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
